lsu_sram_ctrl: RTL and testbench
================================

# lsu_sram_ctrl

Load/store controller that drives the single-port, byte-writable, registered-output SRAM data memory from the pipeline's MEM stage. Accepts one byte/half/word request at a time via valid/ready, converts the byte address into a word address plus byte-lane write strobes, and performs lane alignment with sign/zero extension on reads. Returns a one-cycle response pulse per request. Sits between the five-stage core's MEM stage and the data SRAM.

## Interface
- WORD_ADDR_BITS, 14, SRAM word-address width; byte address width is WORD_ADDR_BITS+2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; = (state==IDLE) & ~rst
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- req_addr  in  WORD_ADDR_BITS+2  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected, no SRAM access made
- sram_addr  out  WORD_ADDR_BITS  SRAM word address
- sram_read  out  1  SRAM read enable
- sram_write  out  4  SRAM byte write strobes, bit i = DI[8i+7:8i]
- sram_DI  out  32  SRAM write data
- sram_DO  in  32  SRAM read data, valid the cycle after the edge sampling sram_read

## Operation
- States: IDLE, ACC (first access), RD (capture first word), with split: ACC2, RD2.
- Accept at edge when req_valid & req_ready; latch addr, size, we, unsigned, wdata. Offset o = req_addr[1:0], word W = req_addr>>2.
- Alignment: byte always aligned; half needs o[0]==0; word needs o==0. req_size==11 always errors.
- Error (illegal size, or misaligned without split): no SRAM strobe; rsp_valid=1, rsp_err=1, rsp_rdata=0 in the cycle after accept; stay IDLE.
- Store: sram_DI = req_wdata rotated left by 8*o bits; strobes = lanes o..o+n-1 (n = 1/2/4 bytes) that fall in word W. IDLE->ACC->IDLE.
- Load: sram_read=1 in ACC; RD captures sram_DO; data = ({second,first} >> 8*o), low n bytes extended per req_unsigned.
- sram_read and sram_write are registered, 0 outside ACC/ACC2; sram_addr and sram_DI hold last value.
- No response backpressure; consumer must take rsp the cycle it is valid.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_err 0, rsp_rdata 0, sram_read 0, sram_write 0, sram_addr 0, sram_DI 0; req_ready 0 while rst high.
- Accept at edge E0. Aligned store: strobes during E0..E1, rsp_valid in E1..E2. Aligned load: sram_read during E0..E1, DO captured at E2, rsp_valid in E2..E3.
- Split store: ACC E0..E1 (word W), ACC2 E1..E2 (word W+1), rsp E2..E3. Split load: rsp E4..E5.
- req_ready returns high the cycle rsp_valid rises; new request may be accepted that cycle.
- Reset mid-operation: request dropped, no response, strobes forced 0 immediately.
- W+1 wraps modulo 2^WORD_ADDR_BITS.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned half/word split into two accesses, W then W+1; first access takes lanes o..3, second lanes 0..o+n-5, same rotated sram_DI both accesses; rsp_err only for size 11.
- Undefined: ACC2/RD2 absent; misaligned half/word returns rsp_err=1 with no SRAM access.

## Test plan
- Store word 0xDEADBEEF @0x0010, load word @0x0010 -> sram_write=1111 addr=4; rsp_rdata=0xDEADBEEF two cycles after accept.
- Store byte 0x80 @0x0013, load signed byte -> 0xFFFFFF80, unsigned -> 0x00000080; strobe 1000, DI=0x80000000.
- Store half 0x1234 @0x0006, load signed half -> 0x00001234; strobe 1100.
- Load word @0x0011 -> without macro rsp_err=1 next cycle, sram_read never 1; with macro after mem word4=0x44332211, word5=0x88776655 -> 0x55443322.
- Split store word @0xFFFF with macro -> accesses to word 0x3FFF strobe 1000 then word 0x0000 strobe 0111.
- Assert rst during ACC of a load -> sram_read 0 immediately, no rsp_valid, req_ready high after release.

Source files
------------

// File: rtl/lsu_sram_ctrl.sv
// lsu_sram_ctrl: MEM-stage load/store controller for a byte-writable registered-output SRAM
// Ports: clk/rst (async active-high); req_* valid/ready request (we, size, unsigned, byte addr, wdata);
// rsp_valid/rsp_rdata/rsp_err one-cycle response; sram_addr/read/write/DI drive the SRAM, sram_DO returns read data.
// Optional: define LSU_MISALIGN_SPLIT_EN to split misaligned half/word accesses into two word accesses.
module lsu_sram_ctrl #(
  parameter int WORD_ADDR_BITS = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [WORD_ADDR_BITS+1:0] req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic [WORD_ADDR_BITS-1:0] sram_addr,
  output logic                      sram_read,
  output logic [3:0]                sram_write,
  output logic [31:0]               sram_DI,
  input  logic [31:0]               sram_DO
);
  typedef enum logic [2:0] {IDLE, ACC, RD
`ifdef LSU_MISALIGN_SPLIT_EN
    , ACC2, RD2
`endif
  } state_t;
  state_t r_state, w_next;
  logic [1:0] r_off, r_size;
  logic r_we, r_uns, r_rsp_valid, r_rsp_err, r_sram_read;
  logic [31:0] r_rsp_rdata, r_sram_DI;
  logic [3:0] r_sram_write;
  logic [WORD_ADDR_BITS-1:0] r_sram_addr;
  logic [3:0] w_mask;
  logic w_mis, w_err_in;
  logic [4:0] w_sh;
  logic [31:0] w_rot, w_lo, w_al, w_ext;
  assign req_ready  = (r_state == IDLE) & ~rst;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign sram_addr  = r_sram_addr;
  assign sram_read  = r_sram_read;
  assign sram_write = r_sram_write;
  assign sram_DI    = r_sram_DI;
  assign w_mask = req_size == 2'd0 ? 4'b0001 : req_size == 2'd1 ? 4'b0011 : 4'b1111;
  assign w_mis  = (req_size == 2'd1 & req_addr[0]) | (req_size == 2'd2 & req_addr[1:0] != 2'd0);
  assign w_sh   = {req_addr[1:0], 3'b000};
  assign w_rot  = (req_wdata << w_sh) | (req_wdata >> (6'd32 - {1'b0, w_sh}));
`ifdef LSU_MISALIGN_SPLIT_EN
  logic r_split;
  logic [3:0] r_strb2;
  logic [31:0] r_first;
  logic [7:0] w_wide;
  assign w_wide   = {4'b0000, w_mask} << req_addr[1:0];
  assign w_err_in = req_size == 2'd3;
  assign w_lo     = r_state == RD2 ? r_first : sram_DO;
`else
  logic [3:0] w_wide;
  assign w_wide   = w_mask << req_addr[1:0];
  assign w_err_in = req_size == 2'd3 | w_mis;
  assign w_lo     = sram_DO;
`endif
  // {second word, first word} shifted down so the addressed byte lands in lane 0
  assign w_al  = 32'({sram_DO, w_lo} >> {r_off, 3'b000});
  assign w_ext = r_size == 2'd0 ? {{24{~r_uns & w_al[7]}}, w_al[7:0]} :
                 r_size == 2'd1 ? {{16{~r_uns & w_al[15]}}, w_al[15:0]} : w_al;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = req_valid & ~w_err_in ? ACC : IDLE;
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC:  w_next = r_we ? (r_split ? ACC2 : IDLE) : RD;
      RD:   w_next = r_split ? ACC2 : IDLE;
      ACC2: w_next = r_we ? IDLE : RD2;
      RD2:  w_next = IDLE;
`else
      ACC:  w_next = r_we ? IDLE : RD;
      RD:   w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_off        <= '0;
      r_size       <= '0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
      r_sram_addr  <= '0;
      r_sram_read  <= 1'b0;
      r_sram_write <= '0;
      r_sram_DI    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split      <= 1'b0;
      r_strb2      <= '0;
      r_first      <= '0;
`endif
    end else begin
      r_state      <= w_next;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_sram_read  <= 1'b0;
      r_sram_write <= '0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_off  <= req_addr[1:0];
          r_size <= req_size;
          r_we   <= req_we;
          r_uns  <= req_unsigned;
`ifdef LSU_MISALIGN_SPLIT_EN
          r_split <= w_mis;
          r_strb2 <= w_wide[7:4];
`endif
          if (w_err_in) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_sram_addr  <= req_addr[WORD_ADDR_BITS+1:2];
            r_sram_DI    <= w_rot;
            r_sram_write <= req_we ? w_wide[3:0] : 4'b0000;
            r_sram_read  <= ~req_we;
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ACC: if (r_we) begin
          if (r_split) begin
            r_sram_addr  <= r_sram_addr + 1'b1;
            r_sram_write <= r_strb2;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
          end
        end
        RD: if (r_split) begin
          r_first     <= sram_DO;
          r_sram_addr <= r_sram_addr + 1'b1;
          r_sram_read <= 1'b1;
        end else begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_ext;
        end
        ACC2: if (r_we) begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
        end
        RD2: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_ext;
        end
`else
        ACC: if (r_we) begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
        end
        RD: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_ext;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// tb_lsu_sram_ctrl: directed self-checking bench for lsu_sram_ctrl with a behavioural SRAM
module tb_lsu_sram_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, sram_read;
  logic [31:0] rsp_rdata, sram_DI, sram_DO;
  logic [13:0] sram_addr;
  logic [3:0] sram_write;
  logic [31:0] mem [0:16383];
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  lsu_sram_ctrl #(.WORD_ADDR_BITS(14)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .sram_addr(sram_addr),
    .sram_read(sram_read), .sram_write(sram_write), .sram_DI(sram_DI), .sram_DO(sram_DO));
  always @(posedge clk) begin
    if (sram_read) sram_DO <= mem[sram_addr];
    for (int i = 0; i < 4; i++) if (sram_write[i]) mem[sram_addr][8*i +: 8] <= sram_DI[8*i +: 8];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic we, input logic [1:0] sz, input logic uns, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask
  task automatic load(input string tag, input logic [1:0] sz, input logic uns, input logic [15:0] a, input logic [31:0] exp);
    start(1'b0, sz, uns, a, 32'h0);
    chk({tag, "_rd"}, {31'b0, sram_read}, 32'd1);
    tick;
    chk({tag, "_wait"}, {31'b0, rsp_valid}, 32'd0);
    tick;
    chk({tag, "_vld"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_rdata, exp);
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    sram_DO = '0;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_strb", {27'b0, sram_read, sram_write}, 32'd0);
    chk("rst_addr_di", {18'b0, sram_addr} | sram_DI, 32'd0);
    tick;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    start(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
    chk("sw_strb", {28'b0, sram_write}, 32'hF);
    chk("sw_addr", {18'b0, sram_addr}, 32'd4);
    chk("sw_di", sram_DI, 32'hDEADBEEF);
    tick;
    chk("sw_rsp", {29'b0, rsp_valid, rsp_err, req_ready}, 32'b101);
    chk("sw_strb_off", {28'b0, sram_write}, 32'h0);
    load("lw", 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
    start(1'b1, 2'd0, 1'b0, 16'h0013, 32'h00000080);
    chk("sb_strb", {28'b0, sram_write}, 32'b1000);
    chk("sb_di", sram_DI, 32'h80000000);
    tick;
    chk("sb_rsp", {31'b0, rsp_valid}, 32'd1);
    load("lb_s", 2'd0, 1'b0, 16'h0013, 32'hFFFFFF80);
    load("lb_u", 2'd0, 1'b1, 16'h0013, 32'h00000080);
    load("lh_s_hi", 2'd1, 1'b0, 16'h0012, 32'hFFFF80AD);
    start(1'b1, 2'd1, 1'b0, 16'h0006, 32'h00001234);
    chk("sh_strb", {28'b0, sram_write}, 32'b1100);
    chk("sh_addr_di", {sram_addr[7:0], sram_DI[31:8]}, 32'h01123400);
    tick;
    load("lh_s", 2'd1, 1'b0, 16'h0006, 32'h00001234);
    start(1'b0, 2'd3, 1'b0, 16'h0010, 32'h0);
    chk("ill_rsp", {29'b0, rsp_valid, rsp_err, sram_read}, 32'b110);
    chk("ill_data", rsp_rdata, 32'h0);
    tick;
    chk("ill_done", {31'b0, rsp_valid}, 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
    start(1'b1, 2'd2, 1'b0, 16'h0010, 32'h44332211);
    tick;
    start(1'b1, 2'd2, 1'b0, 16'h0014, 32'h88776655);
    tick;
    start(1'b0, 2'd2, 1'b0, 16'h0011, 32'h0);
    chk("slw_rd1", {sram_addr[3:0], 3'b0, sram_read}, 32'h41);
    tick;
    chk("slw_gap", {30'b0, sram_read, rsp_valid}, 32'd0);
    tick;
    chk("slw_rd2", {sram_addr[3:0], 3'b0, sram_read}, 32'h51);
    tick;
    chk("slw_wait", {31'b0, rsp_valid}, 32'd0);
    tick;
    chk("slw_rsp", {30'b0, rsp_valid, rsp_err}, 32'b10);
    chk("slw_data", rsp_rdata, 32'h55443322);
    start(1'b1, 2'd2, 1'b0, 16'hFFFF, 32'hDEADBEEF);
    chk("ssw_a1", {sram_addr, 4'b0, sram_write}, {14'h3FFF, 8'b00001000});
    chk("ssw_di", sram_DI, 32'hEFDEADBE);
    tick;
    chk("ssw_a2", {sram_addr, 4'b0, sram_write}, {14'h0000, 8'b00000111});
    tick;
    chk("ssw_rsp", {27'b0, rsp_valid, sram_write}, 32'h10);
`else
    start(1'b0, 2'd2, 1'b0, 16'h0011, 32'h0);
    chk("mis_rsp", {29'b0, rsp_valid, rsp_err, sram_read}, 32'b110);
    chk("mis_data", rsp_rdata, 32'h0);
    tick;
    chk("mis_done", {30'b0, rsp_valid, sram_read}, 32'd0);
    start(1'b1, 2'd1, 1'b0, 16'h0003, 32'h0000ABCD);
    chk("mis_sh", {28'b0, rsp_err, sram_write[2:0]}, 32'h8);
    chk("mis_sh_w3", {31'b0, sram_write[3]}, 32'd0);
    tick;
`endif
    start(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
    chk("rmid_rd", {31'b0, sram_read}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rmid_forced", {29'b0, sram_read, rsp_valid, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmid_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rmid_norsp", {30'b0, rsp_valid, sram_read}, 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
